// File: rtl/audio_pwm_out.sv
// audio_pwm_out: memory-mapped PCM sample FIFO drained by a programmable sample-rate
// timer. Each popped sample sets the duty of a glitch-free PWM output, which drives an
// external RC filter.
//
// Ports:
//   clk, reset          system clock; asynchronous active-low reset
//   we, addr, wd        slave write strobe, region-local byte address (addr[3:2] decoded), write data
//   rd                  registered read data, valid one cycle after addr is presented
//   pwm_out             registered PWM audio output, forced low while disabled
//   sample_tick         one-cycle pulse per sample period; a pop is attempted in the same cycle
//   fifo_low            high while fewer than FIFO_DEPTH/2 samples are queued (refill hint)
//
// Register map (word offsets):
//   0x0 DATA   write pushes wd[15:0]; reads 0
//   0x4 STATUS [0] empty [1] full [2] underrun (sticky) [3] overflow (sticky) [15:8] count
//   0x8 CTRL   [0] enable; [1] clear sticky flags (reads 0); [2] flush FIFO (reads 0)
//   0xC DIV    [15:0] clk cycles per sample; values below 2 are stored as 2
module audio_pwm_out #(
    parameter int FIFO_DEPTH  = 16,
    parameter int PWM_BITS    = 10,
    parameter int DEFAULT_DIV = 1134
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        pwm_out,
    output logic        sample_tick,
    output logic        fifo_low
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] LOW_CNT  = CW'(FIFO_DEPTH / 2);

    // State registers
    logic [15:0]         mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                underrun_q, underrun_d;
    logic                overflow_q, overflow_d;
    logic                enable_q, enable_d;
    logic [15:0]         div_q, div_d;
    logic [15:0]         sample_cnt_q, sample_cnt_d;
    logic [PWM_BITS-1:0] shadow_q, shadow_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                pwm_out_q, pwm_out_d;
    logic [31:0]         rd_q, rd_d;

    // Bus decode
    logic sel_data, sel_ctrl, sel_div;
    logic push, flush, clr;
    assign sel_data = (addr[3:2] == 2'd0);
    assign sel_ctrl = (addr[3:2] == 2'd2);
    assign sel_div  = (addr[3:2] == 2'd3);
    assign push     = we && sel_data;
    assign flush    = we && sel_ctrl && wd[2];
    assign clr      = we && sel_ctrl && wd[1];

    // FIFO status and event qualification
    logic empty, full, tick, pop, push_ok;
    logic [15:0] fifo_rd_dat;
    assign empty       = (count_q == '0);
    assign full        = (count_q == FULL_CNT);
    // >= rather than == so that lowering DIV below the running count still wraps
    assign tick        = enable_q && (sample_cnt_q >= (div_q - 16'd1));
    assign pop         = tick && !empty;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push on a tick.
    // An empty FIFO never pops, so a push on a tick simply lands as the only entry.
    assign push_ok     = push && (!full || pop);
    assign fifo_rd_dat = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        underrun_d   = underrun_q;
        overflow_d   = overflow_q;
        enable_d     = enable_q;
        div_d        = div_q;
        sample_cnt_d = sample_cnt_q;
        shadow_d     = shadow_q;
        duty_d       = duty_q;
        pwm_cnt_d    = pwm_cnt_q;
        pwm_out_d    = 1'b0;
        rd_d         = 32'd0;

        // Pointers / occupancy; flush overrides any same-cycle push or pop
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        // Sticky flags: a new event in the same cycle as a clear keeps the flag set
        underrun_d = (underrun_q && !clr) || (tick && empty);
        overflow_d = (overflow_q && !clr) || (push && full && !pop);

        if (we && sel_ctrl) enable_d = wd[0];
        if (we && sel_div)  div_d    = (wd[15:0] < 16'd2) ? 16'd2 : wd[15:0];

        sample_cnt_d = (!enable_q || tick) ? 16'd0 : sample_cnt_q + 16'd1;

        // Offset binary: invert the sign bit, keep the top PWM_BITS bits
        if (pop) shadow_d = {~fifo_rd_dat[15], fifo_rd_dat[14 -: PWM_BITS-1]};

        // Duty only changes as the PWM counter wraps, so no period is ever truncated
        if (enable_q) begin
            pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
            if (&pwm_cnt_q) duty_d = shadow_q;
        end
        pwm_out_d = enable_q && (pwm_cnt_q < duty_q);

        case (addr[3:2])
            2'd1:    rd_d = {16'd0, 8'(count_q), 4'd0, overflow_q, underrun_q, full, empty};
            2'd2:    rd_d = {31'd0, enable_q};
            2'd3:    rd_d = {16'd0, div_q};
            default: rd_d = 32'd0;
        endcase
    end

    // Sample storage needs no reset: entries are only read after being written
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_ptr_q] <= wd[15:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            underrun_q   <= 1'b0;
            overflow_q   <= 1'b0;
            enable_q     <= 1'b0;
            div_q        <= 16'(DEFAULT_DIV);
            sample_cnt_q <= '0;
            shadow_q     <= '0;
            duty_q       <= '0;
            pwm_cnt_q    <= '0;
            pwm_out_q    <= 1'b0;
            rd_q         <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            underrun_q   <= underrun_d;
            overflow_q   <= overflow_d;
            enable_q     <= enable_d;
            div_q        <= div_d;
            sample_cnt_q <= sample_cnt_d;
            shadow_q     <= shadow_d;
            duty_q       <= duty_d;
            pwm_cnt_q    <= pwm_cnt_d;
            pwm_out_q    <= pwm_out_d;
            rd_q         <= rd_d;
        end
    end

    assign rd          = rd_q;
    assign pwm_out     = pwm_out_q;
    assign sample_tick = tick;
    assign fifo_low    = (count_q < LOW_CNT);

    // Address bits outside [3:2], upper write data and the low sample bits are don't-care
    logic unused_ok;
    assign unused_ok = ^{addr[31:4], addr[1:0], wd[31:16], fifo_rd_dat};

endmodule
